// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: opcodes, ALU op encodings, FSM states and opcode classes for the multicycle controller.
// RV_JUMP_EN (optional) adds the JAL class; the package is identical either way.
package rv_ctrl_pkg;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {CL_ILL, CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_JAL} opclass_t;
    function automatic logic is_mem(input opclass_t c);
        return c == CL_LW || c == CL_SW;
    endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/memory handshake and datapath strobes between controller and datapath.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic       halt, imem_ready, dmem_ready;
    logic       imem_req, dmem_req;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch;
    logic [1:0] alu_op;
    logic       instr_done, illegal;
    modport master (
        input  opcode, halt, imem_ready, dmem_ready,
        output imem_req, dmem_req, pc_write, ir_write, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, branch, alu_op, instr_done, illegal
    );
    modport slave (
        output opcode, halt, imem_ready, dmem_ready,
        input  imem_req, dmem_req, pc_write, ir_write, reg_write, mem_read, mem_write,
               mem_to_reg, alu_src, branch, alu_op, instr_done, illegal
    );
endinterface

// File: rtl/mc_opclass_decode.sv
// mc_opclass_decode: combinational opcode-to-class decode; JAL is recognised only with RV_JUMP_EN.
module mc_opclass_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opclass_t   o_class
);
    always_comb begin
        case (i_opcode)
            OP_R:    o_class = CL_R;
            OP_I:    o_class = CL_I;
            OP_LW:   o_class = CL_LW;
            OP_SW:   o_class = CL_SW;
            OP_BEQ:  o_class = CL_BEQ;
`ifdef RV_JUMP_EN
            OP_JAL:  o_class = CL_JAL;
`endif
            default: o_class = CL_ILL;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Defining RV_JUMP_EN adds JAL: EXEC loads the jump target into PC, WB writes the link register.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);
    state_t   r_state, w_next;
    opclass_t r_class, w_class;
    logic     w_imem_req, w_jal_pc;

    mc_opclass_decode u_dec (.i_opcode(bus.opcode), .o_class(w_class));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_class <= CL_ILL;
        else if (r_state == DECODE) r_class <= w_class;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = (!bus.halt && bus.imem_ready) ? DECODE : FETCH;
            DECODE:  w_next = (w_class == CL_ILL) ? FETCH : EXEC;
            EXEC:    w_next = is_mem(r_class) ? MEM : (r_class == CL_BEQ) ? FETCH : WB;
            MEM:     w_next = !bus.dmem_ready ? MEM : (r_class == CL_LW) ? WB : FETCH;
            default: w_next = FETCH;
        endcase
    end

    // rst_n gates the fetch request so nothing leaves the block while in reset
    assign w_imem_req = r_state == FETCH && !bus.halt && rst_n;
`ifdef RV_JUMP_EN
    assign w_jal_pc = r_state == EXEC && r_class == CL_JAL;
`else
    assign w_jal_pc = 1'b0;
`endif

    always_comb begin
        bus.imem_req   = w_imem_req;
        bus.ir_write   = w_imem_req && bus.imem_ready;
        bus.pc_write   = (w_imem_req && bus.imem_ready) || w_jal_pc;
        bus.illegal    = r_state == DECODE && w_class == CL_ILL;
        bus.alu_src    = r_state == EXEC && (r_class == CL_I || is_mem(r_class));
        bus.alu_op     = r_state != EXEC ? ALU_ADD :
                         (r_class == CL_R || r_class == CL_I) ? ALU_FUNCT :
                         (r_class == CL_BEQ) ? ALU_SUB : ALU_ADD;
        bus.branch     = r_state == EXEC && r_class == CL_BEQ;
        bus.dmem_req   = r_state == MEM;
        bus.mem_read   = r_state == MEM && r_class == CL_LW;
        bus.mem_write  = r_state == MEM && r_class == CL_SW;
        bus.reg_write  = r_state == WB;
        bus.mem_to_reg = r_state == WB && r_class == CL_LW;
        bus.instr_done = (r_state == EXEC && r_class == CL_BEQ) ||
                         (r_state == MEM && r_class == CL_SW && bus.dmem_ready) ||
                         r_state == WB;
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench with randomized instruction stream and wait states.
module tb_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int ill; int lat; int op; int src; int br; int rw; int mr; int mw; int m2r; int dreq; int pcw;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int n_chk = 0;
    int n_pass = 0;
    int cur_wd = 0;
    int dcnt = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    // Expected per-instruction footprint, derived from cycle counts per class plus wait states
    function automatic exp_t model(input logic [6:0] op, input int wi, input int wd);
        exp_t m;
        m = '{ill:0, lat:0, op:0, src:0, br:0, rw:0, mr:0, mw:0, m2r:0, dreq:0, pcw:1};
        case (op)
            7'b0110011: begin m.lat = 4 + wi; m.op = 2; m.rw = 1; end
            7'b0010011: begin m.lat = 4 + wi; m.op = 2; m.src = 1; m.rw = 1; end
            7'b0000011: begin m.lat = 5 + wi + wd; m.src = 1; m.rw = 1; m.mr = 1 + wd; m.m2r = 1; m.dreq = 1 + wd; end
            7'b0100011: begin m.lat = 4 + wi + wd; m.src = 1; m.mw = 1 + wd; m.dreq = 1 + wd; end
            7'b1100011: begin m.lat = 3 + wi; m.op = 1; m.br = 1; end
`ifdef RV_JUMP_EN
            7'b1101111: begin m.lat = 4 + wi; m.rw = 1; m.pcw = 2; end
`endif
            default:    begin m.ill = 1; m.lat = 2 + wi; m.pcw = 1; end
        endcase
        return m;
    endfunction

    // Monitor: per-cycle protocol checks and scoreboard pop on every retire/illegal
    int c, a_op, a_src, a_br, a_rw, a_mr, a_mw, a_m2r, a_dreq, a_pcw, a_irw;
    logic active = 1'b0, prev_rst = 1'b0, prev_halt = 1'b0, just_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", int'({bus.imem_req, bus.dmem_req, bus.pc_write, bus.ir_write, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_src, bus.branch, bus.alu_op,
                bus.instr_done, bus.illegal}), 0);
            active = 1'b0;
            just_done = 1'b0;
        end else begin
            chk("no_dual_mem_req", int'(bus.imem_req && bus.dmem_req), 0);
            chk("no_regw_with_memw", int'(bus.reg_write && bus.mem_write), 0);
            if (!active && bus.halt) chk("halt_gates_imem_req", int'(bus.imem_req), 0);
            if (!active && !bus.halt && (just_done || prev_halt || !prev_rst))
                chk("fetch_req_asserted", int'(bus.imem_req), 1);
            just_done = 1'b0;
            if (!active && bus.imem_req) begin
                active = 1'b1;
                c = 0; a_op = 0; a_src = 0; a_br = 0; a_rw = 0; a_mr = 0; a_mw = 0;
                a_m2r = 0; a_dreq = 0; a_pcw = 0; a_irw = 0;
            end
            if (active) begin
                c++;
                a_op |= int'(bus.alu_op); a_src |= int'(bus.alu_src); a_br += int'(bus.branch);
                a_rw += int'(bus.reg_write); a_mr += int'(bus.mem_read); a_mw += int'(bus.mem_write);
                a_m2r += int'(bus.mem_to_reg); a_dreq += int'(bus.dmem_req);
                a_pcw += int'(bus.pc_write); a_irw += int'(bus.ir_write);
                if (bus.instr_done || bus.illegal) begin
                    if (sb.size() == 0) chk("unexpected_retire", c, 0);
                    else begin
                        e = sb.pop_front();
                        chk("latency", c, e.lat);
                        chk("illegal", int'(bus.illegal), e.ill);
                        chk("instr_done", int'(bus.instr_done), e.ill != 0 ? 0 : 1);
                        chk("alu_op", a_op, e.op);
                        chk("alu_src", a_src, e.src);
                        chk("branch_cycles", a_br, e.br);
                        chk("reg_write_cycles", a_rw, e.rw);
                        chk("mem_read_cycles", a_mr, e.mr);
                        chk("mem_write_cycles", a_mw, e.mw);
                        chk("mem_to_reg_cycles", a_m2r, e.m2r);
                        chk("dmem_req_cycles", a_dreq, e.dreq);
                        chk("pc_write_cycles", a_pcw, e.pcw);
                        chk("ir_write_cycles", a_irw, 1);
                    end
                    active = 1'b0;
                    just_done = 1'b1;
                end
            end
        end
        prev_rst = rst_n;
        prev_halt = bus.halt;
    end

    // Data memory responder: ready after cur_wd wait cycles, random noise outside MEM
    initial begin
        bus.dmem_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.dmem_req) begin
                bus.dmem_ready = (dcnt == cur_wd);
                dcnt++;
            end else begin
                bus.dmem_ready = 1'($urandom % 2);
                dcnt = 0;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.instr_done || bus.illegal) break;
            n++;
            if (n > 60) begin
                chk("done_timeout", n, 0);
                break;
            end
            @(posedge clk); #1;
            bus.imem_ready = 1'($urandom % 2);
            bus.halt = 1'($urandom % 2);
        end
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        bus.halt = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input int wi, input int wd, input int h);
        sb.push_back(model(op, wi, wd));
        cur_wd = wd;
        for (int i = 0; i < h; i++) begin
            bus.halt = 1'b1;
            bus.imem_ready = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        bus.halt = 1'b0;
        for (int i = 0; i < wi; i++) begin
            bus.imem_ready = 1'b0;
            bus.opcode = 7'($urandom);
            @(posedge clk); #1;
        end
        bus.imem_ready = 1'b1;
        bus.opcode = op;
        wait_done();
    endtask

    logic [6:0] pool [7];
    initial begin
        pool = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1111111};
        bus.halt = 1'b0;
        bus.imem_ready = 1'b1;
        bus.opcode = 7'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.imem_ready = 1'b0;
        issue(7'b0110011, 0, 0, 0);
        issue(7'b0000011, 0, 2, 0);
        issue(7'b1100011, 0, 0, 0);
        issue(7'b1111111, 0, 0, 0);
        issue(7'b0110011, 0, 0, 3);
        // SW abandoned by reset in MEM: no scoreboard entry, so any retire is flagged
        cur_wd = 8;
        bus.imem_ready = 1'b1;
        bus.opcode = 7'b0100011;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.dmem_req; i++) begin
            @(posedge clk); #1;
        end
        chk("sw_reached_mem", int'(bus.dmem_req), 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(7'b0010011, 1, 0, 0);
        issue(7'b1101111, 0, 0, 0);
        issue(7'b0100011, 0, 0, 0);
        for (int k = 0; k < 150; k++) begin
            int sel;
            logic [6:0] op;
            sel = int'($urandom % 8);
            op = sel < 7 ? pool[sel] : 7'($urandom);
            issue(op, int'($urandom % 3), int'($urandom % 3), ($urandom % 4 == 0) ? int'($urandom % 4) : 0);
        end
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: opcode  in  7  instruction opcode from IR, valid from DECODE onward.
REQ-004 SHALL have ports: halt  in  1  hold in FETCH; imem_ready / dmem_ready  in  1  memory handshake completion.
REQ-005 SHALL have ports: imem_req, dmem_req  out  1  memory requests held until the matching ready.
REQ-006 SHALL have ports: pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch  out  1  datapath strobes.
REQ-007 SHALL have ports: alu_op  out  2  (00 add, 01 sub/compare, 10 funct-decoded); instr_done  out  1  retire pulse; illegal  out  1  unsupported-opcode pulse.

Function
REQ-008 SHALL implement Moore FSM states FETCH, DECODE, EXEC, MEM, WB; outputs decoded from state plus latched opcode class only.
REQ-009 SHALL, in FETCH with halt=0, assert imem_req; stay in FETCH until imem_ready=1, then pulse ir_write and pc_write (PC+4) in that cycle and go to DECODE.
REQ-010 SHALL, in FETCH with halt=1, deassert imem_req and remain in FETCH; halt SHALL be ignored in all other states.
REQ-011 SHALL, in DECODE, latch opcode class (R=0110011, I=0010011, LW=0000011, SW=0100011, BEQ=1100011); any other opcode pulses illegal for one cycle and returns to FETCH without retiring.
REQ-012 SHALL, in EXEC: R gives alu_src=0, alu_op=10, next WB; I gives alu_src=1, alu_op=10, next WB; LW/SW give alu_src=1, alu_op=00, next MEM; BEQ gives alu_src=0, alu_op=01, branch=1, instr_done=1, next FETCH.
REQ-013 SHALL, in MEM, assert dmem_req plus mem_read (LW) or mem_write (SW), held stable until dmem_ready=1; on ready, LW goes to WB, SW pulses instr_done and goes to FETCH.
REQ-014 SHALL, in WB, assert reg_write for one cycle, mem_to_reg=1 only for LW, pulse instr_done, and go to FETCH.
REQ-015 SHALL yield zero-wait latencies FETCH-to-FETCH: BEQ 3, R/I/SW 4, LW 5 cycles; each wait cycle adds one.
REQ-016 SHALL never assert imem_req and dmem_req in the same cycle, and SHALL never assert reg_write together with mem_write.
REQ-017 SHALL ignore imem_ready outside FETCH and dmem_ready outside MEM.

Reset
REQ-018 SHALL, while rst_n=0, force state to FETCH, clear the latched class, and drive every output to 0 (imem_req gated by rst_n).
REQ-019 SHALL, when rst_n asserts mid-transaction, abandon any outstanding request immediately; first imem_req after reset SHALL appear in the first cycle with rst_n=1.

Configuration
REQ-020 SHALL, when RV_JUMP_EN is defined, decode JAL (1101111) as a class: EXEC asserts pc_write with jump target, next WB writes PC+4 (reg_write=1, mem_to_reg=0), 4-cycle latency.
REQ-021 SHALL, when RV_JUMP_EN is undefined, treat 1101111 as illegal per REQ-011.

Structure
REQ-022 SHALL take opcode constants, alu_op encodings and the state enum from shared package rv_ctrl_pkg.
REQ-023 SHALL place opcode-to-class decode in sub-module mc_opclass_decode (combinational); FSM and output decode stay in multicycle_ctrl.

Verification
REQ-024 SHALL cover: R-type 0110011, readies always 1 -> states FETCH,DECODE,EXEC,WB; reg_write=1 in cycle 4; instr_done in cycle 4; alu_op=10.
REQ-025 SHALL cover: LW 0000011, dmem_ready low for 2 cycles -> mem_read/dmem_req held 3 cycles; WB with mem_to_reg=1; retire at cycle 7.
REQ-026 SHALL cover: BEQ 1100011 -> branch=1, alu_op=01 in cycle 3, instr_done cycle 3, no reg_write or mem strobes.
REQ-027 SHALL cover: opcode 1111111 -> illegal pulse in DECODE, no instr_done, next cycle FETCH with imem_req=1.
REQ-028 SHALL cover: halt=1 in FETCH for 3 cycles -> imem_req=0 throughout; rst_n pulsed low during MEM of SW -> all outputs 0, mem_write never completes, restart in FETCH.
